// File: rtl/ifu_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifu_fetch_ctrl_pkg                                     |
// | Description : Shared constants, fetch FSM state encoding and helper  |
// |               for the instruction-fetch controller.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ifu_fetch_ctrl_pkg;

   localparam int          C_ADDR_W     = 32;
   localparam int          C_DATA_W     = 32;
   localparam logic [31:0] C_RST_PC     = 32'h8000_0000;
   localparam int          C_INST_BYTES = 4;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'b00,
      FETCH_ADDR = 2'b01,
      FETCH_DATA = 2'b10,
      FETCH_HOLD = 2'b11
   } fetch_state_e;

   // Any non-OKAY response (SLVERR/DECERR/EXOKAY) is treated as a fetch error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != 2'b00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifu_fetch_ctrl_if                                      |
// | Description : Fetch-side bus bundle: AXI4-Lite AR/R channels to the  |
// |               instruction memory plus the valid/ready instruction    |
// |               channel to the IDU.                                    |
// |   master : fetch controller (drives arvalid/araddr/rready and the    |
// |            inst_valid/inst/pc/fetch_err outputs)                     |
// |   slave  : memory + IDU side (drives arready/rvalid/rdata/rresp and  |
// |            inst_ready)                                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface ifu_fetch_ctrl_if
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = C_ADDR_W,
   parameter int DATA_W = C_DATA_W
);
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst;
   logic [ADDR_W-1:0] pc;
   logic              fetch_err;

   modport master (
      output arvalid, araddr, rready, inst_valid, inst, pc, fetch_err,
      input  arready, rvalid, rdata, rresp, inst_ready
   );

   modport slave (
      input  arvalid, araddr, rready, inst_valid, inst, pc, fetch_err,
      output arready, rvalid, rdata, rresp, inst_ready
   );
endinterface
`default_nettype wire

// File: rtl/ifu_next_pc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifu_next_pc                                            |
// | Description : Combinational next-PC select. Priority: reset value,   |
// |               then redirect target, then sequential pc+4 (wraps).    |
// |   rst         in  reset request                                      |
// |   branch_en_i in  redirect strobe                                    |
// |   dnpc_i      in  redirect target                                    |
// |   pc_i        in  current PC                                         |
// |   npc_o       out selected next PC                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ifu_next_pc
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W = C_ADDR_W,
   parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(C_RST_PC)
) (
   input  logic              rst,
   input  logic              branch_en_i,
   input  logic [ADDR_W-1:0] dnpc_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] npc_o
);

   always_comb begin
      npc_o = pc_i + ADDR_W'(C_INST_BYTES);
      if (branch_en_i) npc_o = dnpc_i;
      if (rst)         npc_o = RST_PC;
   end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifu_fetch_ctrl                                         |
// | Description : Instruction-fetch sequencer. Owns the fetch PC, issues |
// |               one AXI4-Lite read at a time, holds the returned word  |
// |               for the IDU and discards beats made stale by an EXU    |
// |               redirect.                                              |
// |   clk, rst     synchronous active-high reset                         |
// |   branch_en_i  one-cycle redirect strobe                             |
// |   dnpc_i       redirect target                                       |
// |   bus          ifu_fetch_ctrl_if.master (AR/R channels, IDU channel) |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ifu_fetch_ctrl
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W = C_ADDR_W,
   parameter int                DATA_W = C_DATA_W,
   parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(C_RST_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch_en_i,
   input  logic [ADDR_W-1:0] dnpc_i,
   ifu_fetch_ctrl_if.master  bus
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              flush_q, flush_d;
   logic [ADDR_W-1:0] pc_next_q, pc_next_d;
   logic              redir_pend_q, redir_pend_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] w_npc;

   ifu_next_pc #(
      .ADDR_W (ADDR_W),
      .RST_PC (RST_PC)
   ) u_next_pc (
      .rst         (rst),
      .branch_en_i (branch_en_i),
      .dnpc_i      (dnpc_i),
      .pc_i        (pc_q),
      .npc_o       (w_npc)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      flush_d      = flush_q;
      pc_next_d    = pc_next_q;
      redir_pend_d = redir_pend_q;
      inst_d       = inst_q;
      hold_pc_d    = hold_pc_q;
      err_d        = err_q;

      unique case (state_q)
         FETCH_IDLE: begin
            state_d = FETCH_ADDR;
            if (branch_en_i) pc_d = w_npc;
         end
         FETCH_ADDR: begin
            if (bus.arready) begin
               state_d      = FETCH_DATA;
               redir_pend_d = 1'b0;
               // A redirect seen while the address was on the bus makes the
               // outstanding beat stale; a redirect in this very cycle wins
               // over an older pending one.
               if (branch_en_i) begin
                  pc_d    = w_npc;
                  flush_d = 1'b1;
               end else if (redir_pend_q) begin
                  pc_d    = pc_next_q;
                  flush_d = 1'b1;
               end
            end else if (branch_en_i) begin
               // araddr must stay frozen until the handshake, so park the
               // target instead of touching pc_q.
               pc_next_d    = dnpc_i;
               redir_pend_d = 1'b1;
            end
         end
         FETCH_DATA: begin
            if (branch_en_i) begin
               pc_d    = w_npc;
               flush_d = 1'b1;
            end
            if (bus.rvalid) begin
               if (flush_q || branch_en_i) begin
                  state_d = FETCH_ADDR;
                  flush_d = 1'b0;
               end else begin
                  state_d   = FETCH_HOLD;
                  inst_d    = bus.rdata;
                  hold_pc_d = pc_q;
                  err_d     = resp_is_err(bus.rresp);
               end
            end
         end
         FETCH_HOLD: begin
            // Redirect takes priority over the IDU handshake; w_npc already
            // selects dnpc over pc+4.
            if (branch_en_i || bus.inst_ready) begin
               state_d = FETCH_ADDR;
               pc_d    = w_npc;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH_IDLE;
         pc_q         <= w_npc;   // next-PC mux yields RST_PC under reset
         flush_q      <= 1'b0;
         pc_next_q    <= RST_PC;
         redir_pend_q <= 1'b0;
         inst_q       <= '0;
         hold_pc_q    <= RST_PC;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         flush_q      <= flush_d;
         pc_next_q    <= pc_next_d;
         redir_pend_q <= redir_pend_d;
         inst_q       <= inst_d;
         hold_pc_q    <= hold_pc_d;
         err_q        <= err_d;
      end
   end

   assign bus.arvalid    = (state_q == FETCH_ADDR);
   assign bus.araddr     = pc_q;
   assign bus.rready     = (state_q == FETCH_DATA);
   assign bus.inst_valid = (state_q == FETCH_HOLD);
   assign bus.inst       = inst_q;
   assign bus.pc         = hold_pc_q;
   assign bus.fetch_err  = err_q;

endmodule
`default_nettype wire
